fir_mac_engine: RTL and testbench
=================================

// Module: fir_mac_engine
// PURPOSE
//  Parametrised multi-tap FIR multiply-accumulate engine; successor to the fixed 5-tap program-driven MUL/ADD loop.
//  On a four-phase handshake it filters the waveform ROM around a sample index with a runtime-loadable coefficient bank.
//  It drives an external combinational waveform ROM and returns one DATA_W result per request.
// PARAMETERS
//  DATA_W   8   ROM sample width (unsigned) and result width
//  COEF_W   8   coefficient width (signed two's complement)
//  TAPS     5   tap count, 1..16; CENTER = TAPS/2 (integer division)
//  ADDR_W   8   ROM address width; index range 0..2^ADDR_W-1
//  SHIFT    4   arithmetic right shift applied to the accumulator before output
// PORTS
//  clk         in   1                 rising-edge clock
//  reset       in   1                 asynchronous, active-high reset
//  handshake   in   1                 request; high = start/hold, low = release
//  index       in   ADDR_W            centre sample address, captured at start
//  coef_we     in   1                 coefficient write strobe; honoured in IDLE only
//  coef_addr   in   $clog2(TAPS)      tap to write; values >= TAPS are ignored
//  coef_wdata  in   COEF_W            signed coefficient
//  rom_addr    out  ADDR_W            waveform ROM address (combinational ROM)
//  rom_data    in   DATA_W            waveform ROM data for rom_addr, same cycle
//  result      out  DATA_W            filtered sample, registered, held until next FINISH
//  busy        out  1                 high from start edge until return to IDLE
//  done        out  1                 high in HOLD (result valid)
// BEHAVIOUR
//  Reset (async): state=IDLE; result=0, busy=0, done=0, rom_addr=0, acc=0, tap=0;
//   coef[CENTER]=1<<SHIFT, all other coefs 0 (identity filter). Reset mid-run aborts immediately; no partial result.
//  ACC_W = DATA_W+COEF_W+$clog2(TAPS)+1, signed; product = $signed({1'b0,data}) * coef, sign-extended into acc.
//  FSM: IDLE -> ADDR <-> MAC -> FINISH -> HOLD -> IDLE.
//  IDLE: if handshake=1 at edge: idx_q<=index, acc<=0, tap<=0, busy<=1, state<=ADDR. Else coef_we writes coef.
//  ADDR: rom_addr = clamp(idx_q + tap - CENTER) computed signed, width ADDR_W+2; <0 -> 0, >2^ADDR_W-1 -> max.
//   Edge: data_q<=rom_data, state<=MAC.
//  MAC: acc<=acc+product(data_q,coef[tap]); if tap==TAPS-1 -> FINISH, else tap++ and -> ADDR.
//  FINISH: result<=out_fn(acc>>>SHIFT); done<=1; state<=HOLD.
//  HOLD: waits while handshake=1; at edge with handshake=0: done<=0, busy<=0, state<=IDLE.
//  Latency: start edge E0; result and done valid after edge E0+2*TAPS+1 (11 cycles at TAPS=5).
//  handshake dropped mid-run is ignored; the run completes, passes through HOLD for one cycle, then returns to IDLE.
//  handshake held high after IDLE re-entry starts a new run (level-sensitive).
//  coef_we outside IDLE is ignored with no side effect; a coefficient write and a start in the same IDLE cycle both take effect.
//  rom_addr holds its last value outside ADDR.
// CONFIGURATION
//  FIR_SAT_EN defined: out_fn saturates the shifted signed acc to the range 0..2^DATA_W-1.
//  FIR_SAT_EN undefined: out_fn takes the low DATA_W bits of the shifted acc (wrap-around).
// TESTING  (defaults; ROM model rom[i]=i)
//  1 reset, no coef writes, index=100, handshake=1 -> done after 11 cycles, result=100, busy=1 throughout run.
//  2 all 5 coefs=16, index=50 -> sum 48..52=250 -> result=250; drop handshake -> done=0, busy=0 next edge.
//  3 all coefs=16, index=0 -> addrs clamp {0,0,0,1,2} -> result=3; index=255 -> 1272 -> SAT: 255, no SAT: 248.
//  4 coef[2]=-16, others 0, index=10 -> acc>>>4=-10 -> SAT: 0, no SAT: 246.
//  5 reset asserted during tap 3 MAC -> busy=0, done=0, result=0 at once; coefs back to identity; rerun index=7 -> 7.
//  6 coef_we (addr 2, data 0) while busy -> ignored; run gives identity result; handshake low mid-run -> still completes.

Source files
------------

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: TAPS-tap FIR multiply-accumulate over an external combinational waveform ROM, four-phase handshake.
// Optional FIR_SAT_EN: saturate the output to 0..2^DATA_W-1; when undefined the low DATA_W bits wrap.
module fir_mac_engine #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int TAPS   = 5,
  parameter int ADDR_W = 8,
  parameter int SHIFT  = 4,
  localparam int CA_W  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     handshake,
  input  logic [ADDR_W-1:0]        index,
  input  logic                     coef_we,
  input  logic [CA_W-1:0]          coef_addr,
  input  logic signed [COEF_W-1:0] coef_wdata,
  output logic [ADDR_W-1:0]        rom_addr,
  input  logic [DATA_W-1:0]        rom_data,
  output logic [DATA_W-1:0]        result,
  output logic                     busy,
  output logic                     done
);
  localparam int CENTER = TAPS / 2;
  localparam int ACC_W  = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam int AW2    = ADDR_W + 2;
  localparam logic [CA_W-1:0] TAP_LAST = CA_W'(TAPS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, MAC, FINISH, HOLD} state_t;

  state_t                     state_reg, state_next;
  logic [ADDR_W-1:0]          idx_reg;
  logic [CA_W-1:0]            tap_reg;
  logic [DATA_W-1:0]          data_reg;
  logic signed [ACC_W-1:0]    acc_reg;
  logic [ADDR_W-1:0]          rom_addr_reg;
  logic [DATA_W-1:0]          result_reg;
  logic                       busy_reg;
  logic                       done_reg;
  logic signed [COEF_W-1:0]   coef_arr [TAPS];

  logic signed [AW2-1:0]      addr_s;
  logic [ADDR_W-1:0]          addr_clamp;
  logic signed [DATA_W+COEF_W:0] prod;
  logic signed [ACC_W-1:0]    acc_next;
  logic signed [ACC_W-1:0]    acc_shr;
  logic [DATA_W-1:0]          out_val;

  // Coefficient bank resets to an identity filter: only the centre tap is 1.0 after the output shift.
  for (genvar gi = 0; gi < TAPS; gi++) begin : g_coef
    localparam logic signed [COEF_W-1:0] RST_VAL = (gi == CENTER) ? COEF_W'(1 << SHIFT) : COEF_W'(0);
    logic signed [COEF_W-1:0] coef_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset)
        coef_q <= RST_VAL;
      else if (state_reg == IDLE && coef_we && coef_addr == CA_W'(gi))
        coef_q <= coef_wdata;
    end
    assign coef_arr[gi] = coef_q;
  end

  // Window address is computed two bits wider so underflow and overflow are both visible.
  always_comb begin
    addr_s = AW2'(idx_reg) + AW2'(tap_reg) - AW2'(CENTER);
    if (addr_s[AW2-1])
      addr_clamp = '0;
    else if (addr_s[ADDR_W])
      addr_clamp = '1;
    else
      addr_clamp = addr_s[ADDR_W-1:0];
  end

  always_comb begin
    prod     = $signed({1'b0, data_reg}) * coef_arr[tap_reg];
    acc_next = acc_reg + ACC_W'(prod);
    acc_shr  = acc_reg >>> SHIFT;
`ifdef FIR_SAT_EN
    if (acc_shr[ACC_W-1])
      out_val = '0;
    else if (|acc_shr[ACC_W-1:DATA_W])
      out_val = '1;
    else
      out_val = acc_shr[DATA_W-1:0];
`else
    out_val = acc_shr[DATA_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (handshake) state_next = ADDR;
      ADDR:    state_next = MAC;
      MAC:     state_next = (tap_reg == TAP_LAST) ? FINISH : ADDR;
      FINISH:  state_next = HOLD;
      HOLD:    if (!handshake) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The ROM is combinational, so the address must be live during ADDR and held otherwise.
  always_comb begin
    rom_addr = (state_reg == ADDR) ? addr_clamp : rom_addr_reg;
    result   = result_reg;
    busy     = busy_reg;
    done     = done_reg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_reg      <= '0;
      tap_reg      <= '0;
      data_reg     <= '0;
      acc_reg      <= '0;
      rom_addr_reg <= '0;
      result_reg   <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      unique case (state_reg)
        IDLE: if (handshake) begin
          idx_reg  <= index;
          acc_reg  <= '0;
          tap_reg  <= '0;
          busy_reg <= 1'b1;
        end
        ADDR: begin
          data_reg     <= rom_data;
          rom_addr_reg <= addr_clamp;
        end
        MAC: begin
          acc_reg <= acc_next;
          if (tap_reg != TAP_LAST) tap_reg <= tap_reg + 1'b1;
        end
        FINISH: begin
          result_reg <= out_val;
          done_reg   <= 1'b1;
        end
        HOLD: if (!handshake) begin
          done_reg <= 1'b0;
          busy_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fir_mac_engine.sv
// Scoreboard bench for fir_mac_engine at default parameters with ROM model rom[i]=i.
module tb_fir_mac_engine;
  logic       clk = 1'b0;
  logic       reset;
  logic       handshake;
  logic [7:0] index;
  logic       coef_we;
  logic [2:0] coef_addr;
  logic [7:0] coef_wdata;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic [7:0] result;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  int mcoef [5];
  int sb [$];

  fir_mac_engine dut (
    .clk        (clk),
    .reset      (reset),
    .handshake  (handshake),
    .index      (index),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .result     (result),
    .busy       (busy),
    .done       (done)
  );

  assign rom_data = rom_addr;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clampf(input int a);
    if (a < 0) return 0;
    if (a > 255) return 255;
    return a;
  endfunction

  function automatic int model(input int idx);
    int acc = 0;
    int s;
    for (int t = 0; t < 5; t++) acc += mcoef[t] * clampf(idx + t - 2);
    s = acc >>> 4;
`ifdef FIR_SAT_EN
    if (s < 0) s = 0;
    if (s > 255) s = 255;
`else
    s = s & 255;
`endif
    return s;
  endfunction

  task automatic set_identity();
    for (int t = 0; t < 5; t++) mcoef[t] = (t == 2) ? 16 : 0;
  endtask

  task automatic coef_write(input int addr, input int data);
    logic [7:0] d;
    logic [2:0] a;
    d = data[7:0];
    a = addr[2:0];
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    if (addr < 5) mcoef[addr] = $signed(d);
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic run(input int idx, input bit disturb, input bit wr, input int waddr, input int wdata);
    int n;
    int lows;
    int exp;
    logic [7:0] i8;
    logic [7:0] d8;
    logic [2:0] a3;
    i8 = idx[7:0];
    d8 = wdata[7:0];
    a3 = waddr[2:0];
    @(negedge clk);
    index = i8; handshake = 1'b1;
    if (wr) begin
      coef_we = 1'b1; coef_addr = a3; coef_wdata = d8;
      if (waddr < 5) mcoef[waddr] = $signed(d8);
    end
    sb.push_back(model(idx));
    @(posedge clk); #1;
    coef_we = 1'b0;
    n = 0;
    lows = busy ? 0 : 1;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!done && !busy) lows++;
      if (disturb && n == 3) begin
        handshake = 1'b0;
        coef_we = 1'b1; coef_addr = 3'd2; coef_wdata = 8'd0;
      end
      if (disturb && n == 4) coef_we = 1'b0;
    end
    exp = sb.pop_front();
    check_eq("latency", n, 11);
    check_eq("busy_run_low", lows, 0);
    check_eq("result", int'(result), exp);
    check_eq("rom_hold", int'(rom_addr), clampf(idx + 2));
    if (handshake) begin
      repeat (2) @(posedge clk);
      #1;
      check_eq("hold_done", int'(done), 1);
      @(negedge clk);
      handshake = 1'b0;
    end
    @(posedge clk); #1;
    check_eq("rel_done", int'(done), 0);
    check_eq("rel_busy", int'(busy), 0);
    check_eq("result_kept", int'(result), exp);
    $display("run idx=%0d result=%0d expected=%0d latency=%0d", idx, result, exp, n);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; handshake = 1'b0; index = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    set_identity();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_result", int'(result), 0);
    check_eq("rst_rom_addr", int'(rom_addr), 0);
    @(negedge clk);
    reset = 1'b0;

    // identity filter
    run(100, 1'b0, 1'b0, 0, 0);

    // boxcar; out-of-range coefficient address must not alias
    for (int t = 0; t < 5; t++) coef_write(t, 16);
    coef_write(7, 99);
    coef_write(5, -50);
    run(50, 1'b0, 1'b0, 0, 0);

    // clamping at both ends of the ROM
    run(0, 1'b0, 1'b0, 0, 0);
    run(255, 1'b0, 1'b0, 0, 0);

    // negative result; centre coefficient written in the same cycle as the start
    coef_write(0, 0); coef_write(1, 0); coef_write(3, 0); coef_write(4, 0);
    run(10, 1'b0, 1'b1, 2, -16);

    // reset during tap-3 MAC
    for (int t = 0; t < 5; t++) coef_write(t, 16);
    @(negedge clk);
    index = 8'd100; handshake = 1'b1;
    @(posedge clk);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_done", int'(done), 0);
    check_eq("abort_result", int'(result), 0);
    check_eq("abort_rom_addr", int'(rom_addr), 0);
    handshake = 1'b0;
    set_identity();
    @(negedge clk);
    reset = 1'b0;
    run(7, 1'b0, 1'b0, 0, 0);

    // busy-time coefficient write ignored, handshake dropped mid-run
    run(9, 1'b1, 1'b0, 0, 0);
    run(20, 1'b0, 1'b0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
